// File: rtl/param_dual_port_ram.sv
// Simple dual-port RAM: one write port with byte enables, one pipelined read port,
// configurable read-during-write policy and a reset-triggered clear engine.
module param_dual_port_ram #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned WRITE_FIRST    = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_en,
  input  logic [ADDR_W-1:0]      w_addr,
  input  logic [DATA_W/8-1:0]    w_be,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   r_en,
  input  logic [ADDR_W-1:0]      r_addr,
  output logic [DATA_W-1:0]      data_out,
  output logic                   valid_out,
  output logic                   busy
);

  localparam int unsigned        BE_W      = DATA_W / 8;
  localparam logic [ADDR_W:0]    DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                clr_we;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                wr_acc, rd_acc, rd_in_range;
  logic [DATA_W-1:0]   rd_word;
  logic                out_vld_d;
  logic [DATA_W-1:0]   out_data_d;
  logic [DATA_W-1:0]   data_out_q;
  logic                valid_out_q;

  // Clear engine state register; without the engine the FSM is parked in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        clr_we = 1'b1;
        ptr_d  = ptr_q + ADDR_W'(1);
        if (ptr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
    endcase
  end

  assign busy        = (state_q == ST_CLEAR);
  assign wr_acc      = w_en && !busy && !rst && ({1'b0, w_addr} < DEPTH_L);
  assign rd_acc      = r_en && !busy && !rst;
  assign rd_in_range = ({1'b0, r_addr} < DEPTH_L);

  // Array writes: clear engine has priority, user writes are byte-masked
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem_q[ptr_q] <= '0;
      end else if (wr_acc) begin
        for (int b = 0; b < BE_W; b++) begin
          if (w_be[b]) mem_q[w_addr][8*b +: 8] <= data_in[8*b +: 8];
        end
      end
    end
  end

  // Read word; in write-first mode a same-address write is merged in bytewise
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem_q[r_addr];
      if ((WRITE_FIRST != 0) && wr_acc && (w_addr == r_addr)) begin
        for (int b = 0; b < BE_W; b++) begin
          if (w_be[b]) rd_word[8*b +: 8] = data_in[8*b +: 8];
        end
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic              s1_vld_q;
      logic [DATA_W-1:0] s1_data_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_vld_q  <= 1'b0;
          s1_data_q <= '0;
        end else begin
          s1_vld_q <= rd_acc;
          if (rd_acc) s1_data_q <= rd_word;
        end
      end

      assign out_vld_d  = s1_vld_q;
      assign out_data_d = s1_data_q;
    end else begin : g_lat1
      assign out_vld_d  = rd_acc;
      assign out_data_d = rd_word;
    end
  endgenerate

  // Output register: data holds between completed reads
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      valid_out_q <= out_vld_d;
      if (out_vld_d) data_out_q <= out_data_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_param_dual_port_ram.sv
// Directed bench for param_dual_port_ram: three instances cover default,
// latency-2/write-first and shallow-depth/no-clear configurations.
module tb_param_dual_port_ram;

  logic        clk;
  logic        rst       [3];
  logic        w_en      [3];
  logic [7:0]  w_addr    [3];
  logic [1:0]  w_be      [3];
  logic [15:0] data_in   [3];
  logic        r_en      [3];
  logic [7:0]  r_addr    [3];
  logic [15:0] data_out  [3];
  logic        valid_out [3];
  logic        busy      [3];

  int n_tests = 0;
  int n_fail  = 0;

  param_dual_port_ram u_dut0 (
    .clk(clk), .rst(rst[0]), .w_en(w_en[0]), .w_addr(w_addr[0]), .w_be(w_be[0]),
    .data_in(data_in[0]), .r_en(r_en[0]), .r_addr(r_addr[0]),
    .data_out(data_out[0]), .valid_out(valid_out[0]), .busy(busy[0])
  );

  param_dual_port_ram #(.RD_LATENCY(2), .WRITE_FIRST(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .w_en(w_en[1]), .w_addr(w_addr[1]), .w_be(w_be[1]),
    .data_in(data_in[1]), .r_en(r_en[1]), .r_addr(r_addr[1]),
    .data_out(data_out[1]), .valid_out(valid_out[1]), .busy(busy[1])
  );

  param_dual_port_ram #(.DEPTH(200), .CLEAR_ON_RESET(0)) u_dut2 (
    .clk(clk), .rst(rst[2]), .w_en(w_en[2]), .w_addr(w_addr[2]), .w_be(w_be[2]),
    .data_in(data_in[2]), .r_en(r_en[2]), .r_addr(r_addr[2]),
    .data_out(data_out[2]), .valid_out(valid_out[2]), .busy(busy[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input int d, input logic [7:0] a, input logic [1:0] be, input logic [15:0] v);
    w_en[d] = 1'b1; w_addr[d] = a; w_be[d] = be; data_in[d] = v;
    tick();
    w_en[d] = 1'b0;
  endtask

  // Latency-1 read: strobe right after the sampling edge, then data must hold
  task automatic rd1(input int d, input logic [7:0] a, input logic [15:0] exp, input string tag);
    r_en[d] = 1'b1; r_addr[d] = a;
    tick();
    r_en[d] = 1'b0;
    check({tag, "_valid"}, 32'(valid_out[d]), 32'd1);
    check({tag, "_data"}, 32'(data_out[d]), 32'(exp));
    tick();
    check({tag, "_vld_off"}, 32'(valid_out[d]), 32'd0);
    check({tag, "_hold"}, 32'(data_out[d]), 32'(exp));
  endtask

  task automatic count_busy(input int d, output int n);
    n = 0;
    while (busy[d] && n < 2000) begin
      n++;
      tick();
    end
  endtask

  int  n;
  logic seen;

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; w_en[d] = 1'b0; w_addr[d] = '0; w_be[d] = '0;
      data_in[d] = '0; r_en[d] = 1'b0; r_addr[d] = '0;
    end
    tick();
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;

    check("rst_busy0", 32'(busy[0]), 32'd1);
    check("rst_valid0", 32'(valid_out[0]), 32'd0);
    check("rst_data0", 32'(data_out[0]), 32'd0);
    check("rst_busy2", 32'(busy[2]), 32'd0);

    // Default instance: clear length after a reset pulse
    count_busy(0, n);
    check("init_clear_len", 32'(n), 32'd256);
    wr(0, 8'd5, 2'b11, 16'hBEEF);
    rd1(0, 8'd5, 16'hBEEF, "prefill");
    rst[0] = 1'b1; tick(); rst[0] = 1'b0;
    count_busy(0, n);
    check("clear_len", 32'(n), 32'd256);
    rd1(0, 8'd5, 16'h0000, "cleared5");

    // Byte enables
    wr(0, 8'd3, 2'b11, 16'h1234);
    wr(0, 8'd3, 2'b10, 16'hABCD);
    rd1(0, 8'd3, 16'hAB34, "byte_en");

    // Read-during-write, read-first
    wr(0, 8'd7, 2'b11, 16'h0001);
    w_en[0] = 1'b1; w_addr[0] = 8'd7; w_be[0] = 2'b01; data_in[0] = 16'h00FF;
    r_en[0] = 1'b1; r_addr[0] = 8'd7;
    tick();
    w_en[0] = 1'b0; r_en[0] = 1'b0;
    check("rdw_old_valid", 32'(valid_out[0]), 32'd1);
    check("rdw_old_data", 32'(data_out[0]), 32'h0001);
    tick();
    rd1(0, 8'd7, 16'h00FF, "rdw_after");

    // Reset mid-clear, with requests hammering addr 3 throughout
    w_en[0] = 1'b1; w_addr[0] = 8'd3; w_be[0] = 2'b11; data_in[0] = 16'hFFFF;
    r_en[0] = 1'b1; r_addr[0] = 8'd3;
    rst[0] = 1'b1; tick(); rst[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (valid_out[0]) seen = 1'b1;
      tick();
    end
    check("midclr_busy", 32'(busy[0]), 32'd1);
    rst[0] = 1'b1; tick(); rst[0] = 1'b0;
    n = 0;
    while (busy[0] && n < 2000) begin
      if (valid_out[0]) seen = 1'b1;
      n++;
      tick();
    end
    w_en[0] = 1'b0; r_en[0] = 1'b0;
    check("midclr_len", 32'(n), 32'd256);
    check("midclr_no_valid", 32'(seen), 32'd0);
    rd1(0, 8'd3, 16'h0000, "midclr_noarray");

    // Latency-2 / write-first instance
    count_busy(1, n);
    check("l2_idle", 32'(busy[1]), 32'd0);
    for (int k = 0; k < 4; k++) wr(1, 8'(k), 2'b11, 16'(k + 100));
    for (int c = 0; c < 6; c++) begin
      r_en[1] = (c < 4); r_addr[1] = 8'(c);
      tick();
      check("l2_valid", 32'(valid_out[1]), (c >= 1 && c <= 4) ? 32'd1 : 32'd0);
      if (c >= 1 && c <= 4) check("l2_data", 32'(data_out[1]), 32'(c + 99));
    end
    r_en[1] = 1'b0;

    wr(1, 8'd7, 2'b11, 16'h0001);
    w_en[1] = 1'b1; w_addr[1] = 8'd7; w_be[1] = 2'b01; data_in[1] = 16'h00FF;
    r_en[1] = 1'b1; r_addr[1] = 8'd7;
    tick();
    w_en[1] = 1'b0; r_en[1] = 1'b0;
    check("wf_lat_gap", 32'(valid_out[1]), 32'd0);
    tick();
    check("wf_valid", 32'(valid_out[1]), 32'd1);
    check("wf_data", 32'(data_out[1]), 32'h00FF);

    w_en[1] = 1'b1; w_addr[1] = 8'd7; w_be[1] = 2'b10; data_in[1] = 16'h5500;
    r_en[1] = 1'b1; r_addr[1] = 8'd7;
    tick();
    w_en[1] = 1'b0; r_en[1] = 1'b0;
    tick();
    check("wf_merge", 32'(data_out[1]), 32'h55FF);

    // Shallow instance: out-of-range accesses and reset priority
    wr(2, 8'd199, 2'b11, 16'h1111);
    wr(2, 8'd250, 2'b11, 16'hDEAD);
    wr(2, 8'd200, 2'b11, 16'hBEEF);
    rd1(2, 8'd199, 16'h1111, "d200_last");
    rd1(2, 8'd250, 16'h0000, "d200_oor250");
    rd1(2, 8'd200, 16'h0000, "d200_oor200");
    rd1(2, 8'd199, 16'h1111, "d200_keep");
    wr(2, 8'd10, 2'b11, 16'h0001);
    rst[2] = 1'b1;
    w_en[2] = 1'b1; w_addr[2] = 8'd10; w_be[2] = 2'b11; data_in[2] = 16'h7777;
    r_en[2] = 1'b1; r_addr[2] = 8'd10;
    tick();
    rst[2] = 1'b0; w_en[2] = 1'b0; r_en[2] = 1'b0;
    check("rstwin_valid", 32'(valid_out[2]), 32'd0);
    check("rstwin_data", 32'(data_out[2]), 32'd0);
    rd1(2, 8'd10, 16'h0001, "rstwin_mem");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
